// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART 8N1 receiver feeding a small byte FIFO with a valid/ready output stream.
//
// The serial input passes through a two-flop synchronizer. Start-bit detection re-checks the
// line at mid-bit, and every later bit is sampled at its centre. Completed bytes are pushed on
// the stop-sample cycle. The FIFO head is driven from registered storage, so a byte is never
// shown on the same cycle it is pushed.
//
// Optional feature: define UART_RX_PARITY_EN to receive 8E1 frames. This adds a PARITY state
// and the parity_err output. Bytes with bad parity are dropped.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   rx          asynchronous serial input, idle high
//   data_out    byte at FIFO head
//   data_valid  FIFO non-empty
//   data_ready  consumer accepts data_out when data_valid && data_ready
//   frame_err   one-cycle pulse: stop bit sampled low
//   overrun     one-cycle pulse: byte arrived while FIFO full and was dropped
//   parity_err  (UART_RX_PARITY_EN only) one-cycle pulse: parity mismatch
//   fifo_count  bytes currently held
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx,
  output logic [7:0]                    data_out,
  output logic                          data_valid,
  input  logic                          data_ready,
  output logic                          frame_err,
  output logic                          overrun,
`ifdef UART_RX_PARITY_EN
  output logic                          parity_err,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned CntW  = $clog2(CLKS_PER_BIT);
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);

  localparam logic [CntW-1:0]  HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0]  BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0]  CntOne   = CntW'(1);
  localparam logic [AddrW:0]   CountMax = (AddrW + 1)'(FIFO_DEPTH);
  localparam logic [AddrW:0]   CountOne = (AddrW + 1)'(1);
  localparam logic [AddrW-1:0] PtrOne   = AddrW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StWaitHigh
  } state_e;

  // Synchronizer
  logic rx_meta_q, rx_s_q;

  // Receiver
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            frame_err_q, frame_err_d;
  logic            push;
`ifdef UART_RX_PARITY_EN
  logic            par_bad_q, par_bad_d;
  logic            parity_err_q, parity_err_d;
`endif

  // FIFO
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   count_q, count_d;
  logic             overrun_q, overrun_d;
  logic             pop, push_ok, full;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d = StStart;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      StStart: begin
        // Mid-bit recheck rejects short glitches on the line.
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          state_d = rx_s_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cnt_q == BitLast) begin
          cnt_d     = '0;
          par_bad_d = rx_s_q ^ (^shift_q);
          state_d   = StStop;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
`endif
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
`ifdef UART_RX_PARITY_EN
          parity_err_d = par_bad_q;
`endif
          if (rx_s_q) begin
`ifdef UART_RX_PARITY_EN
            push = !par_bad_q;
`else
            push = 1'b1;
`endif
            state_d = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StWaitHigh;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StWaitHigh: begin
        // Line held low (break); wait for it to return high before hunting again.
        if (rx_s_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    full      = (count_q == CountMax);
    pop       = data_valid && data_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push_ok   = push && (!full || pop);
    overrun_d = push && full && !pop;
    count_d   = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CountOne;
    end else if (!push_ok && pop) begin
      count_d = count_q - CountOne;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
      count_q     <= count_d;
      overrun_q   <= overrun_d;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
    end
  end

  assign data_out   = mem_q[rd_ptr_q];
  assign data_valid = (count_q != '0);
  assign fifo_count = count_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: frames are driven bit by bit on rx, and a negedge monitor
// records accepted bytes and event pulses for the checks in the main sequence.
module tb_uart_rx_fifo;

  localparam int unsigned CPB   = 16;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       data_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;
  logic [2:0] fifo_count;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int pe_cnt = 0;
  int v_cyc  = 0;
  logic [7:0] got[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) pe_cnt++;
`endif
      if (data_valid) v_cyc++;
      if (data_valid && data_ready) got.push_back(data_out);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] got_at(input int i);
    logic [7:0] none;
    none = 8'hxx;
    if (i < got.size()) return got[i];
    return none;
  endfunction

  task automatic send_bit(input logic v);
    rx = v;
    tick(CPB);
  endtask

  task automatic send_data(input logic [7:0] b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic send_stop(input int low_bits);
    for (int i = 0; i < low_bits; i++) send_bit(1'b0);
    send_bit(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_data(b);
`ifdef UART_RX_PARITY_EN
    send_bit(^b);
`endif
    send_stop(0);
  endtask

  initial begin
    int base, fe0, ov0, v0, pe0;

    // Reset state
    reset = 1'b1;
    tick(3);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_data", 32'(data_out), 32'h00);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    reset = 1'b0;
    tick(4);

    // 1: single byte with consumer ready
    data_ready = 1'b1;
    base = got.size(); fe0 = fe_cnt; ov0 = ov_cnt; v0 = v_cyc;
    send_frame(8'h55);
    tick(4);
    check("t1_byte", 32'(got_at(base)), 32'h55);
    check("t1_nbytes", 32'(got.size() - base), 32'd1);
    check("t1_valid_cycles", 32'(v_cyc - v0), 32'd1);
    check("t1_ferr", 32'(fe_cnt - fe0), 32'd0);
    check("t1_ovr", 32'(ov_cnt - ov0), 32'd0);

    // 2: back-to-back frames held, then drained
    data_ready = 1'b0;
    base = got.size();
    send_frame(8'hA5);
    send_frame(8'h3C);
    tick(4);
    check("t2_count2", 32'(fifo_count), 32'd2);
    check("t2_head", 32'(data_out), 32'hA5);
    check("t2_valid", 32'(data_valid), 32'd1);
    data_ready = 1'b1;
    tick(1);
    check("t2_count1", 32'(fifo_count), 32'd1);
    check("t2_head2", 32'(data_out), 32'h3C);
    tick(1);
    check("t2_count0", 32'(fifo_count), 32'd0);
    check("t2_pop0", 32'(got_at(base)), 32'hA5);
    check("t2_pop1", 32'(got_at(base + 1)), 32'h3C);

    // 3: short low glitch is rejected
    fe0 = fe_cnt; v0 = v_cyc;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(CPB * 12);
    check("t3_valid_cycles", 32'(v_cyc - v0), 32'd0);
    check("t3_ferr", 32'(fe_cnt - fe0), 32'd0);

    // 4: framing error with a long low stop, then recovery
    fe0 = fe_cnt; v0 = v_cyc; base = got.size();
    send_data(8'h81);
`ifdef UART_RX_PARITY_EN
    send_bit(^8'h81);
`endif
    send_stop(2);
    tick(4);
    check("t4_ferr", 32'(fe_cnt - fe0), 32'd1);
    check("t4_count", 32'(fifo_count), 32'd0);
    check("t4_no_valid", 32'(v_cyc - v0), 32'd0);
    send_frame(8'h12);
    tick(4);
    check("t4_recover", 32'(got_at(base)), 32'h12);

    // 5: overrun on a fifth byte into a full FIFO
    data_ready = 1'b0;
    ov0 = ov_cnt; base = got.size();
    for (int i = 1; i <= 5; i++) send_frame(8'(i));
    tick(4);
    check("t5_ovr", 32'(ov_cnt - ov0), 32'd1);
    check("t5_count", 32'(fifo_count), 32'd4);
    data_ready = 1'b1;
    tick(8);
    check("t5_d0", 32'(got_at(base)), 32'h01);
    check("t5_d1", 32'(got_at(base + 1)), 32'h02);
    check("t5_d2", 32'(got_at(base + 2)), 32'h03);
    check("t5_d3", 32'(got_at(base + 3)), 32'h04);
    check("t5_nbytes", 32'(got.size() - base), 32'd4);
    check("t5_empty", 32'(fifo_count), 32'd0);

    // 6: reset mid-frame with one byte buffered
    data_ready = 1'b0;
    send_frame(8'h33);
    tick(4);
    check("t6_pre_count", 32'(fifo_count), 32'd1);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    reset = 1'b1;
    tick(1);
    check("t6_rst_valid", 32'(data_valid), 32'd0);
    check("t6_rst_data", 32'(data_out), 32'h00);
    check("t6_rst_count", 32'(fifo_count), 32'd0);
    check("t6_rst_ferr", 32'(frame_err), 32'd0);
    check("t6_rst_ovr", 32'(overrun), 32'd0);
    reset = 1'b0;
    v0 = v_cyc;
    tick(CPB * 12);
    check("t6_no_push", 32'(v_cyc - v0), 32'd0);
    data_ready = 1'b1;
    base = got.size();
    send_frame(8'h7E);
    tick(4);
    check("t6_after", 32'(got_at(base)), 32'h7E);
    check("t6_count", 32'(fifo_count), 32'd0);

`ifdef UART_RX_PARITY_EN
    pe0 = pe_cnt; v0 = v_cyc;
    send_data(8'h7E);
    send_bit(~(^8'h7E));
    send_stop(0);
    tick(4);
    check("t6_par_err", 32'(pe_cnt - pe0), 32'd1);
    check("t6_par_drop", 32'(v_cyc - v0), 32'd0);
`else
    pe0 = pe_cnt;
    check("t6_no_par", 32'(pe_cnt - pe0), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART 8N1 receiver with an output byte FIFO.
- Counterpart to the fabric's UART transmitter. Serves as the on-chip RX front end and as the bench-side monitor on the TX pin.
- Samples an asynchronous serial line and reassembles bytes.
- Buffers bytes in a small FIFO and presents them on a valid/ready stream interface.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be >= 4 and even.
- FIFO_DEPTH, 4, number of bytes buffered; power of two, >= 2.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial input; idle high.
- data_out  output  8  byte at FIFO head.
- data_valid  output  1  FIFO non-empty.
- data_ready  input  1  consumer accepts data_out when data_valid && data_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: byte received while FIFO full, byte dropped.
- fifo_count  output  clog2(FIFO_DEPTH)+1  bytes currently held.

Behaviour:
- Reset values:
  - data_valid=0, data_out=0, frame_err=0, overrun=0, fifo_count=0.
  - Synchronizer flops = 1; FSM = IDLE; FIFO pointers = 0.
- Reset asserted mid-frame aborts the frame; nothing is pushed.
- rx passes through a 2-flop synchronizer (rx_s). All FSM decisions use rx_s.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: when rx_s=0, go to START with bit counter = 0.
- START: wait CLKS_PER_BIT/2 cycles, then sample rx_s.
  - rx_s=1: glitch; return to IDLE; no output.
  - rx_s=0: go to DATA.
- DATA: every CLKS_PER_BIT cycles, sample rx_s into the shift register, LSB first. After 8 samples, go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample rx_s.
  - rx_s=1: push the byte (subject to FIFO rules below); go to IDLE.
  - rx_s=0: pulse frame_err on the next cycle; discard the byte; go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s=1 (break condition); then go to IDLE.
- Back-to-back frames: a new start bit is accepted the cycle after the STOP sample. No extra idle time is required.
- FIFO behaviour:
  - Push happens on the STOP sample cycle. data_valid/data_out reflect the new byte on the next cycle, i.e. 1 cycle latency from the stop-bit sample.
  - Pop happens on data_valid && data_ready. data_out shows the next entry on the following cycle (registered head).
  - Push while full, with no pop that cycle: byte dropped; overrun pulses 1 cycle; contents unchanged.
  - Push while full with a simultaneous pop: both succeed; count stays FIFO_DEPTH; no overrun.
  - Push while empty with data_ready=1: byte is stored. It is popped no earlier than the cycle it is first shown valid; there is no fall-through.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_count updates the cycle after push/pop.
- Latency from the first rx falling edge to data_valid:
  - 2 (sync) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles.
  - ±1 cycle for edge alignment.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP and samples one even-parity bit after CLKS_PER_BIT cycles.
  - Extra output port parity_err (1 bit, reset 0) pulses 1 cycle after the stop sample if the parity mismatched.
  - A mismatched byte is discarded even if the stop bit is good.
  - Frame becomes 8E1; latency grows by CLKS_PER_BIT.
- Undefined: no PARITY state and no parity_err port; frame is 8N1.

Test Plan:
1. CLKS_PER_BIT=16, data_ready=1; send 0x55 as 8N1:
   - data_valid pulses 1 cycle with data_out=0x55.
   - frame_err=0, overrun=0.
2. Send 0xA5 then 0x3C back-to-back, no idle gap, data_ready=0:
   - fifo_count=2; data_out=0xA5.
   - Raise data_ready: 0xA5 then 0x3C are popped on consecutive cycles; fifo_count ends at 0.
3. Drive rx low for 4 cycles, then high:
   - FSM returns to IDLE; no data_valid, no frame_err.
4. Send 0x81 with the stop bit held low for 2 bit times, then high:
   - frame_err pulses once; fifo_count stays 0.
   - Next frame 0x12 is received correctly.
5. FIFO_DEPTH=4, data_ready=0; send 0x01..0x05:
   - overrun pulses once on the 5th byte; fifo_count=4.
   - Drained order is 0x01,0x02,0x03,0x04.
6. Assert reset for 1 cycle midway through the DATA bits of 0xFF:
   - All outputs return to reset values; no push.
   - A following 0x7E is received correctly.
   - With UART_RX_PARITY_EN: 0x7E sent with a wrong parity bit gives parity_err=1 and no push.
